// File: rtl/uart_stream_arbiter.sv
// uart_stream_arbiter: shares one UART byte transmitter between two
// non-stallable byte sources (ch0 = ADC samples, ch1 = SD-card reads).
// Each source lands in its own first-word-fall-through FIFO; bursts of up to
// BURST_MAX bytes are granted round-robin.
// Build option: define ARB_FRAMING_EN to frame every burst with a header byte
// (0xA0 | channel) and a length byte. Left undefined, only payload is sent.

// Per-channel FWFT FIFO with registered occupancy and saturating drop counter.
module uart_stream_arbiter_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_data,
    input  logic                         pop,
    output logic [7:0]                   head_c,
    output logic [$clog2(DEPTH):0]       count,
    output logic [7:0]                   drops
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    // Fullness is judged on the count at the start of the cycle, so a
    // same-cycle pop never rescues a write to a full FIFO.
    assign full    = (count == CW'(DEPTH));
    assign push_ok = wr_valid && !full;
    assign pop_ok  = pop && (count != '0);
    assign head_c  = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_valid && full && (drops != 8'hFF)) begin
                drops <= drops + 8'd1;
            end
        end
    end
endmodule

// Top level: two channel FIFOs plus the burst arbiter/framer FSM.
module uart_stream_arbiter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch0_axiiv,
    input  logic [7:0] ch0_axiid,
    input  logic       ch1_axiiv,
    input  logic [7:0] ch1_axiid,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       grant,
    output logic       busy,
    output logic [7:0] ch0_drops,
    output logic [7:0] ch1_drops
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LW = (CW > 8) ? CW : 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LENGTH,
        ST_PAYLOAD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    len_q;
    logic [7:0]    len_d;
    logic          grant_q;
    logic          grant_d;
    logic          sel;
    logic          pop0;
    logic          pop1;
    logic [7:0]    head0;
    logic [7:0]    head1;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    uart_stream_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (ch0_axiiv),
        .wr_data  (ch0_axiid),
        .pop      (pop0),
        .head_c   (head0),
        .count    (count0),
        .drops    (ch0_drops)
    );

    uart_stream_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (ch1_axiiv),
        .wr_data  (ch1_axiid),
        .pop      (pop1),
        .head_c   (head1),
        .count    (count1),
        .drops    (ch1_drops)
    );

    // Burst length is the current occupancy clipped to BURST_MAX.
    function automatic logic [7:0] burst_len(input logic [CW-1:0] cnt);
        if (LW'(cnt) > LW'(BURST_MAX)) begin
            return 8'(BURST_MAX);
        end
        return 8'(cnt);
    endfunction

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

    // State, latched burst length and owning channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= 8'd0;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            grant_q <= grant_d;
        end
    end

    // Next-state, transmit byte selection and FIFO pops.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        grant_d  = grant_q;
        sel      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        pop0     = 1'b0;
        pop1     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count0 != '0) || (count1 != '0)) begin
                    // On a tie the channel that did not own the last burst wins.
                    if ((count0 != '0) && (count1 != '0)) begin
                        sel = ~grant_q;
                    end else begin
                        sel = (count1 != '0);
                    end
                    grant_d = sel;
                    len_d   = sel ? burst_len(count1) : burst_len(count0);
`ifdef ARB_FRAMING_EN
                    state_d = ST_HEADER;
`else
                    state_d = ST_PAYLOAD;
`endif
                end
            end
`ifdef ARB_FRAMING_EN
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA0 | {7'd0, grant_q};
                if (tx_ready) begin
                    state_d = ST_LENGTH;
                end
            end
            ST_LENGTH: begin
                tx_valid = 1'b1;
                tx_data  = len_q;
                if (tx_ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = grant_q ? head1 : head0;
                if (tx_ready) begin
                    pop0  = !grant_q;
                    pop1  = grant_q;
                    len_d = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Directed bench for uart_stream_arbiter. Expected streams follow the build:
// with ARB_FRAMING_EN defined each burst is preceded by header and length.
module tb_uart_stream_arbiter;
`ifdef ARB_FRAMING_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ch0_axiiv = 1'b0;
    logic [7:0] ch0_axiid = 8'd0;
    logic       ch1_axiiv = 1'b0;
    logic [7:0] ch1_axiid = 8'd0;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       grant;
    logic       busy;
    logic [7:0] ch0_drops;
    logic [7:0] ch1_drops;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] cap_data[$];
    int         cap_cyc[$];
    logic       cap_gnt[$];
    logic [7:0] exp_data[$];
    int         exp_len[$];
    logic       exp_g[$];
    logic [7:0] pl[$];

    uart_stream_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .ch0_axiiv (ch0_axiiv),
        .ch0_axiid (ch0_axiid),
        .ch1_axiiv (ch1_axiiv),
        .ch1_axiid (ch1_axiid),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .grant     (grant),
        .busy      (busy),
        .ch0_drops (ch0_drops),
        .ch1_drops (ch1_drops)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every byte that will be handshaken at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            cap_data.push_back(tx_data);
            cap_cyc.push_back(cyc);
            cap_gnt.push_back(grant);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        cap_data.delete();
        cap_cyc.delete();
        cap_gnt.delete();
        exp_data.delete();
        exp_len.delete();
        exp_g.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_ready = 1'b0;
        ch0_axiiv = 1'b0;
        ch1_axiiv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    // One input cycle; called and returns 1 time unit after a rising edge.
    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        ch0_axiiv = v0;
        ch0_axiid = d0;
        ch1_axiiv = v1;
        ch1_axiid = d1;
        @(posedge clk);
        #1;
        ch0_axiiv = 1'b0;
        ch1_axiiv = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Append one expected burst built from pl for channel g.
    task automatic add_burst(input logic g);
`ifdef ARB_FRAMING_EN
        exp_data.push_back(8'hA0 | {7'd0, g});
        exp_data.push_back(8'(pl.size()));
`endif
        exp_len.push_back(pl.size() + HDR);
        foreach (pl[i]) exp_data.push_back(pl[i]);
        exp_g.push_back(g);
        pl.delete();
    endtask

    // Compare captured stream against expectation; optionally check that
    // bursts are bubble-free and separated by exactly one idle cycle.
    task automatic check_stream(input string tag, input bit timing);
        int pos;
        pos = 0;
        check({tag, "_count"}, cap_data.size(), exp_data.size());
        if (cap_data.size() == exp_data.size()) begin
            foreach (exp_data[i]) check({tag, "_byte"}, cap_data[i], exp_data[i]);
            foreach (exp_len[b]) begin
                check({tag, "_grant"}, cap_gnt[pos], exp_g[b]);
                if (timing) begin
                    if (b > 0) check({tag, "_gap"}, cap_cyc[pos] - cap_cyc[pos-1], 2);
                    for (int j = 1; j < exp_len[b]; j++)
                        check({tag, "_contig"}, cap_cyc[pos+j] - cap_cyc[pos+j-1], 1);
                end
                pos += exp_len[b];
            end
        end
        clear_logs();
    endtask

    // Wait (bounded) for the edge on which the k-th byte is handshaken.
    task automatic wait_bytes(input string tag, input int k);
        int n;
        n = 0;
        while (cap_data.size() < k && n < 60) begin
            @(posedge clk);
            n++;
        end
        check(tag, cap_data.size() >= k, 1);
    endtask

    initial begin
        int k;
        do_reset();

        // Reset values.
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant", grant, 1);
        check("rst_busy", busy, 0);
        check("rst_drops0", ch0_drops, 0);
        check("rst_drops1", ch1_drops, 0);
        @(posedge clk);
        #1;

        // Single ch0 burst of 3, queued behind a 1-byte ch1 burst.
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h55);
        drive(1'b1, 8'h11, 1'b0, 8'h00);
        drive(1'b1, 8'h22, 1'b0, 8'h00);
        drive(1'b1, 8'h33, 1'b0, 8'h00);
        tx_ready = 1'b1;
        run(30);
        pl = '{8'h55};             add_burst(1'b1);
        pl = '{8'h11, 8'h22, 8'h33}; add_burst(1'b0);
        check_stream("single", 1'b1);
        @(negedge clk);
        check("single_grant_end", grant, 0);
        check("single_busy_end", busy, 0);
        @(posedge clk);
        #1;

        // Tie and round-robin: 10 bytes on ch0, 2 on ch1, same cycles.
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h5A);
        for (int i = 0; i < 10; i++)
            drive(1'b1, 8'(8'h40 + i), i < 2, 8'(8'h80 + i));
        tx_ready = 1'b1;
        run(60);
        pl = '{8'h5A}; add_burst(1'b1);
        pl = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47}; add_burst(1'b0);
        pl = '{8'h80, 8'h81}; add_burst(1'b1);
        pl = '{8'h48, 8'h49}; add_burst(1'b0);
        check_stream("rr", 1'b1);

        // Backpressure for 5 cycles right after the first ch0 payload byte.
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h5A);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC1 + i), 1'b0, 8'h00);
        tx_ready = 1'b1;
        k = (1 + HDR) + HDR + 1;
        wait_bytes("bp_reach", k);
        #1 tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", tx_valid, 1);
            check("bp_hold_data", tx_data, 8'hC2);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        run(30);
        pl = '{8'h5A}; add_burst(1'b1);
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4}; add_burst(1'b0);
        check_stream("bp", 1'b0);

        // Overflow: 20 bytes into a 16-deep ch1 FIFO with the UART stalled.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 1'b1, 8'(8'h60 + i));
        @(negedge clk);
        check("ovf_drops1", ch1_drops, 4);
        check("ovf_drops0", ch0_drops, 0);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        run(70);
        pl = '{8'h60}; add_burst(1'b1);
        pl = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68}; add_burst(1'b1);
        pl = '{8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F}; add_burst(1'b1);
        check_stream("ovf", 1'b1);

        // Reset during PAYLOAD (drop counter still holds 4 from above).
        tx_ready = 1'b0;
        drive(1'b1, 8'hF0, 1'b0, 8'h00);
        drive(1'b1, 8'hF1, 1'b0, 8'h00);
        if (HDR > 0) begin
            tx_ready = 1'b1;
            wait_bytes("mid_hdr_reach", HDR);
            #1 tx_ready = 1'b0;
        end
        @(negedge clk);
        check("mid_pre_valid", tx_valid, 1);
        check("mid_pre_data", tx_data, 8'hF0);
        check("mid_pre_drops1", ch1_drops, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drops0", ch0_drops, 0);
        check("mid_rst_drops1", ch1_drops, 0);
        check("mid_rst_grant", grant, 1);
        @(posedge clk);
        #1 tx_ready = 1'b1;
        run(20);
        check("mid_no_trailing", cap_data.size(), HDR);
        check("mid_idle_after", busy, 0);
        clear_logs();

        // Two single-byte ch1 bursts; raw bytes only unless framing is built in.
        do_reset();
        tx_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'hB1);
        drive(1'b0, 8'h00, 1'b1, 8'hB2);
        run(20);
        pl = '{8'hB1}; add_burst(1'b1);
        pl = '{8'hB2}; add_burst(1'b1);
        check_stream("raw", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
